// File: rtl/key_judge_pkg.sv
// Shared types and helpers for the key judge: FSM states, judge results and
// the saturating counter increment used for score and combo.
package key_judge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RESULT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        HIT  = 2'd1,
        MISS = 2'd2
    } result_e;

    // Counters are carried as 32-bit values so one helper serves any SCORE_W up to 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/key_judge_debounce.sv
// One key lane: 2-flop synchroniser, debounce counter, stable level and a
// one-cycle press pulse on the stable rising edge.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_key,
    output logic o_level,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q, stable_dly_d;

    // The counter only runs while the synchronised level disagrees with the stable one.
    always_comb begin
        sync1_d      = i_key;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        cnt_d        = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
        end
    end

    assign o_level = stable_q;
    assign o_press = stable_q & ~stable_dly_q;

endmodule

// File: rtl/key_judge.sv
// Multi-lane key judge: debounces each key lane and scores presses against
// notes handed over by the sequencer within a fixed timing window.
module key_judge
    import key_judge_pkg::*;
#(
    parameter int NUM_KEYS     = 3,
    parameter int DEBOUNCE_CYC = 16,
    parameter int WINDOW_CYC   = 64,
    parameter int SCORE_W      = 8,
    localparam int LANE_W      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [NUM_KEYS-1:0] i_key,
    input  logic                i_note_valid,
    input  logic [LANE_W-1:0]   i_note_lane,
    output logic                o_note_ready,
    output logic [NUM_KEYS-1:0] o_led,
    output logic                o_hit,
    output logic                o_miss,
    output logic [SCORE_W-1:0]  o_score,
    output logic [SCORE_W-1:0]  o_combo
);

    localparam int WIN_W = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYC - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] press;

    state_e             state_q, state_d;
    result_e            result_q, result_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] combo_q, combo_d;

    logic target_press;
    logic other_press;
    logic lane_valid;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
        key_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_debounce (
            .clk    (clk),
            .nrst   (nrst),
            .i_key  (i_key[g]),
            .o_level(level[g]),
            .o_press(press[g])
        );
    end

    // Split this cycle's presses into the latched target lane and everything else.
    always_comb begin
        target_press = 1'b0;
        other_press  = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (lane_q == LANE_W'(i)) begin
                target_press = target_press | press[i];
            end else begin
                other_press = other_press | press[i];
            end
        end
    end

    assign lane_valid = int'(i_note_lane) < NUM_KEYS;

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q  <= IDLE;
            result_q <= NONE;
            lane_q   <= '0;
            win_q    <= '0;
            score_q  <= '0;
            combo_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            lane_q   <= lane_d;
            win_q    <= win_d;
            score_q  <= score_d;
            combo_q  <= combo_d;
        end
    end

    // Score and combo change on the edge that enters RESULT, together with the pulse.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        lane_d   = lane_q;
        win_d    = win_q;
        score_d  = score_q;
        combo_d  = combo_q;
        case (state_q)
            IDLE: begin
                if (i_note_valid) begin
                    lane_d = i_note_lane;
                    win_d  = '0;
                    if (lane_valid) begin
                        state_d = ARMED;
                    end else begin
                        state_d  = RESULT;
                        result_d = MISS;
                        combo_d  = '0;
                    end
                end
            end
            ARMED: begin
                if (target_press) begin
                    state_d  = RESULT;
                    result_d = HIT;
                    score_d  = SCORE_W'(sat_inc(32'(score_q), 32'(SCORE_MAX)));
                    combo_d  = SCORE_W'(sat_inc(32'(combo_q), 32'(SCORE_MAX)));
                end else if (other_press || (win_q == WIN_LAST)) begin
                    state_d  = RESULT;
                    result_d = MISS;
                    combo_d  = '0;
                end else begin
                    win_d = win_q + 1'b1;
                end
            end
            RESULT: begin
                state_d  = IDLE;
                result_d = NONE;
            end
            default: begin
                state_d  = IDLE;
                result_d = NONE;
            end
        endcase
    end

    always_comb begin
        o_note_ready = (state_q == IDLE);
        o_hit        = (state_q == RESULT) && (result_q == HIT);
        o_miss       = (state_q == RESULT) && (result_q == MISS);
    end

    assign o_led   = level;
    assign o_score = score_q;
    assign o_combo = combo_q;

endmodule

// File: doc/key_judge.md
# key_judge

Parametrised key-input judge for the rhythm-game top level. It generalises the fixed three push-key handling to NUM_KEYS lanes. Each lane gets a synchroniser and a debouncer, and the judge scores each debounced press against a target note inside a configurable timing window. It sits between the raw board keys and the score/LED/7-segment display logic, and takes notes from the note sequencer through a valid/ready handshake.

## Interface
- NUM_KEYS, 3, number of key lanes (1..8)
- DEBOUNCE_CYC, 16, consecutive stable cycles before a debounced level changes (≥2)
- WINDOW_CYC, 64, judge window length in cycles after note acceptance (≥1)
- SCORE_W, 8, width of score and combo counters
- clk  in  1  system clock
- nrst  in  1  reset; synchronous, active-high despite the name
- i_key  in  NUM_KEYS  raw asynchronous key levels, 1 = pressed
- i_note_valid  in  1  sequencer presents a note
- i_note_lane  in  $clog2(NUM_KEYS) (min 1)  target lane of the presented note
- o_note_ready  out  1  judge can accept a note
- o_led  out  NUM_KEYS  debounced key levels
- o_hit  out  1  one-cycle pulse, correct lane pressed in window
- o_miss  out  1  one-cycle pulse, wrong lane, timeout or invalid lane
- o_score  out  SCORE_W  saturating hit count
- o_combo  out  SCORE_W  saturating consecutive-hit count

## Operation
- Per lane: 2-flop synchroniser, then a debounce counter. The counter clears whenever the synchronised level equals the stable level. When the levels differ for DEBOUNCE_CYC consecutive cycles, the stable level toggles and the counter clears.
- Press event = stable rises (stable & ~stable_d). It is a one-cycle pulse. Releases generate no event.
- FSM states: IDLE, ARMED, RESULT.
- IDLE:
  - o_note_ready = 1.
  - On i_note_valid & o_note_ready: latch the lane and clear the window counter.
  - If the lane is < NUM_KEYS, go to ARMED. Otherwise go to RESULT(miss).
- ARMED, evaluated each cycle in this priority:
  - press on the target lane → RESULT(hit);
  - else any other press → RESULT(miss);
  - else window counter == WINDOW_CYC-1 → RESULT(miss);
  - else increment the window counter.
- RESULT: drive o_hit or o_miss for exactly this cycle, then go to IDLE.
- On hit: o_score+1 and o_combo+1, both saturating at 2^SCORE_W-1.
- On miss: o_combo ← 0. o_score is unchanged.
- Presses in IDLE or RESULT are ignored and do not break the combo.
- i_note_lane is sampled only at acceptance. Changes while not ready are ignored.

## Timing
- Reset values: o_led=0, o_hit=0, o_miss=0, o_score=0, o_combo=0, state=IDLE, o_note_ready=1.
- Reset mid-operation: on the next edge, the pending note is dropped with no hit/miss pulse, debounced levels are cleared, and counters are cleared. A key still held after reset produces a fresh press after debounce.
- Debounce latency, with edge 0 as the first edge that samples a raw change:
  - stable level changes at edge DEBOUNCE_CYC+1;
  - o_led follows in the same cycle;
  - the press pulse is valid in the cycle after edge DEBOUNCE_CYC+1.
- Judge latency: a press visible in ARMED cycle c gives o_hit/o_miss in cycle c+1. o_score/o_combo update at the same edge the pulse rises.
- Window: the note is accepted at edge A.
  - Presses visible in the cycles after edges A..A+WINDOW_CYC-1 are judged.
  - With no press, o_miss rises at edge A+WINDOW_CYC.
  - A press visible in the acceptance cycle (before edge A) is not judged.
- o_note_ready is 0 in ARMED and RESULT. The minimum note-to-note spacing is 3 cycles.
- Simultaneous target and non-target presses in the same cycle → hit.
- A key bouncing faster than DEBOUNCE_CYC never changes o_led.

## Structure
- Package key_judge_pkg holds:
  - the state enum (IDLE, ARMED, RESULT);
  - the result enum (NONE, HIT, MISS);
  - a sat_inc function for SCORE_W counters.
- Sub-module key_debounce (one lane: synchroniser, counter, stable level, press pulse), instantiated NUM_KEYS times with generate.
- key_judge holds the FSM, window counter, lane latch, and score/combo registers.

## Test plan
Default parameters apply: NUM_KEYS=3, DEBOUNCE_CYC=16, WINDOW_CYC=64, SCORE_W=8.
- Reset: hold nrst=1 for 2 cycles, release → all outputs 0, o_note_ready=1, no pulses for 100 cycles with keys idle.
- Note lane 1, hold i_key[1] high from the cycle after acceptance → o_led[1] rises at edge 17 after the key, o_hit pulses one cycle later, o_score=1, o_combo=1.
- Note lane 2 with no press → o_miss at exactly edge A+64; o_combo=0; o_score unchanged.
- Note lane 0, press lane 2 → o_miss; three hits first give combo=3, then the miss resets it to 0 while o_score stays 3.
- Bounce: toggle i_key[0] every 10 cycles for 200 cycles → o_led[0] stays 0 and no hit/miss; then a steady press gives exactly one event.
- Boundaries:
  - i_note_lane=3 → o_miss in the cycle after acceptance;
  - 260 consecutive hits → o_score and o_combo hold at 255;
  - nrst asserted while ARMED → no pulse, state IDLE, o_score=0.
